cdic_regs: RTL and testbench
============================

# cdic_regs

CD-i CD Interface Controller (CDIC) slave model on the 68070 system bus. It is selected by the top-level address decoder for the 64 KB window at 0x300000–0x30FFFF. It provides the 15 KB sector buffer RAM and the CDIC register file, with byte-lane writes and a registered read path. It is a purely bus-facing model: no CD drive, DMA or interrupt generation.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 23: CPU word address, bits [23:1]. Only [15:1] are decoded; [23:16] are ignored.
- `din` in 16: CPU write data.
- `dout` out 16: read data. Registered; 0 after reset.
- `uds` in 1: upper data strobe; selects the din/dout [15:8] lane.
- `lds` in 1: lower data strobe; selects the [7:0] lane.
- `write_strobe` in 1: 1 = write cycle, 0 = read cycle.
- `cs` in 1: chip select from the decoder (byte address[23:16] == 0x30).

## Operation
- Access condition: `acc = cs && (uds || lds)`.
  - Write when `acc && write_strobe`.
  - Read when `acc && !write_strobe`.
- Address map (byte offset = {address[15:1], 0}):
  - 0x0000–0x3BFF: buffer RAM, 7680 × 16.
  - 0x3C00: command. R/W, reset 0.
  - 0x3C02: time high. R/W, reset 0.
  - 0x3C04: time low. R/W, reset 0.
  - 0x3C06: file. R/W, bits [7:0] only; bits [15:8] read 0.
  - 0x3C08: channel high. R/W.
  - 0x3C0A: channel low. R/W.
  - 0x3C0C: audio channel mask. R/W.
  - 0x3FF4: ABUF status. R/W.
  - 0x3FF6: XBUF status. R/W.
  - 0x3FF8: DMA control. R/W.
  - 0x3FFA: audio control. R/W.
  - 0x3FFC: interrupt vector. R/W, reset 0x0F00.
  - 0x3FFE: data buffer. R/W.
  - All other offsets (0x3C0E–0x3FF2, 0x4000–0xFFFE) read 0 and ignore writes.
  - Every register not listed with a reset value resets to 0.
- Byte lanes: `uds` writes din[15:8]; `lds` writes din[7:0]; both together write the full word. The unselected byte keeps its value. This applies to RAM and registers alike.
- Command side effect: any write to 0x3C00 also sets XBUF bit 15 (command accepted) on the same edge.
  - If the same cycle also writes XBUF directly, the direct write wins for the bytes it covers.
- Read-to-clear: the first cycle of a read access to ABUF or XBUF clears bit 15 of that register.
  - "First cycle" means acc was 0 on the previous cycle, or the word address differed.
  - The value returned on dout is the pre-clear value.
- Writes repeat on every cycle the write condition holds; this is idempotent.
- No bus-ack output: the top level treats the CDIC as always ready.

## Timing
- Write: captured on the rising edge where the write condition holds; visible to reads one cycle later.
- Read: dout updates every clock from the address and data sampled at that edge, i.e. 1-cycle latency.
  - dout is valid from the second cycle of a held access onward.
  - The CPU holds the address for ≥ 2 clocks.
- dout updates whether or not `cs` is asserted. With `cs` low it shows the decoded value of the current address offset.
- Reset (asynchronous): all registers take their reset values and dout = 0 immediately. RAM contents are undefined and not cleared.
- Reset asserted mid-access: the access is aborted and no partial write occurs after reset assertion.
- Read and write cannot occur in the same cycle (single `write_strobe`).

## Structure
- Package `cdic_pkg`:
  - register offset constants (CMD, TIME_HI, TIME_LO, FILE, CHAN_HI, CHAN_LO, ACHAN, ABUF, XBUF, DMACTL, AUDCTL, IVEC, DBUF);
  - RAM size constant 7680;
  - reset-value constants.
- Sub-module `cdic_ram`: 7680 × 16 synchronous single-port RAM with two byte-write enables and registered read. It maps to block RAM.
- Top level: address decode, register file, read-to-clear edge detector, output mux.
  - Register reads are registered to match the RAM latency.

## Test plan
- Reset: hold reset_n = 0, then release. Read 0x3FFC → 0x0F00; read 0x3C00 → 0x0000; dout = 0 during reset.
- RAM byte lanes:
  - write 0x1234 to 0x0100 with uds = lds = 1;
  - write 0xAB00 with uds only;
  - read 0x0100 → 0xAB34;
  - read 0x3BFE after writing 0xFFFF → 0xFFFF.
- File register: write 0xFFFF to 0x3C06 → reads 0x00FF. Write to 0x3C10 → read 0x3C10 returns 0 and no register changes.
- Command side effect and read-to-clear:
  - write 0x002A to 0x3C00;
  - read 0x3FF6 → 0x8000;
  - a second, separate read of 0x3FF6 → 0x0000.
- Held read: hold a read of ABUF (preset to 0x8001) for 5 cycles. dout stays 0x8001 for the whole access; the next access reads 0x0001.
- Async reset mid-write: assert reset_n = 0 during a write of 0x5555 to 0x3FF8, between edges. Register reads 0 after release.

Source files
------------

// File: rtl/cdic_pkg.sv
// Shared constants for the CD-i CDIC bus model: register offsets, reset values,
// RAM geometry and the register address decoder.
package cdic_pkg;

    localparam int RAM_WORDS = 7680;
    localparam int NUM_REGS  = 13;

    typedef enum logic [3:0] {
        R_CMD, R_TIME_HI, R_TIME_LO, R_FILE, R_CHAN_HI, R_CHAN_LO, R_ACHAN,
        R_ABUF, R_XBUF, R_DMACTL, R_AUDCTL, R_IVEC, R_DBUF
    } reg_idx_e;

    localparam logic [15:0] CMD     = 16'h3C00;
    localparam logic [15:0] TIME_HI = 16'h3C02;
    localparam logic [15:0] TIME_LO = 16'h3C04;
    localparam logic [15:0] FILE    = 16'h3C06;
    localparam logic [15:0] CHAN_HI = 16'h3C08;
    localparam logic [15:0] CHAN_LO = 16'h3C0A;
    localparam logic [15:0] ACHAN   = 16'h3C0C;
    localparam logic [15:0] ABUF    = 16'h3FF4;
    localparam logic [15:0] XBUF    = 16'h3FF6;
    localparam logic [15:0] DMACTL  = 16'h3FF8;
    localparam logic [15:0] AUDCTL  = 16'h3FFA;
    localparam logic [15:0] IVEC    = 16'h3FFC;
    localparam logic [15:0] DBUF    = 16'h3FFE;

    localparam logic [15:0] IVEC_RST = 16'h0F00;
    localparam logic [15:0] REG_RST  = 16'h0000;

    typedef struct packed {
        logic     hit;
        reg_idx_e idx;
    } reg_dec_t;

    function automatic reg_dec_t reg_decode(logic [15:0] ofs);
        reg_dec_t d;
        d.hit = 1'b1;
        d.idx = R_CMD;
        case (ofs)
            CMD:     d.idx = R_CMD;
            TIME_HI: d.idx = R_TIME_HI;
            TIME_LO: d.idx = R_TIME_LO;
            FILE:    d.idx = R_FILE;
            CHAN_HI: d.idx = R_CHAN_HI;
            CHAN_LO: d.idx = R_CHAN_LO;
            ACHAN:   d.idx = R_ACHAN;
            ABUF:    d.idx = R_ABUF;
            XBUF:    d.idx = R_XBUF;
            DMACTL:  d.idx = R_DMACTL;
            AUDCTL:  d.idx = R_AUDCTL;
            IVEC:    d.idx = R_IVEC;
            DBUF:    d.idx = R_DBUF;
            default: d.hit = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [NUM_REGS-1:0][15:0] regs_rst();
        logic [NUM_REGS-1:0][15:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[i] = REG_RST;
        r[R_IVEC] = IVEC_RST;
        return r;
    endfunction

endpackage

// File: rtl/cdic_regs_if.sv
// 68070-side bus as seen by the CDIC: word address, data, byte strobes, direction, select.
interface cdic_regs_if;
    logic [22:0] address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        uds;
    logic        lds;
    logic        write_strobe;
    logic        cs;

    modport master (output address, din, uds, lds, write_strobe, cs, input dout);
    modport slave  (input address, din, uds, lds, write_strobe, cs, output dout);
endinterface

// File: rtl/cdic_ram.sv
// Sector buffer: single-port RAM with per-byte write enables and registered read.
module cdic_ram
    import cdic_pkg::*;
(
    input  logic        clk,
    input  logic [12:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  we,
    output logic [15:0] rdata
);
    logic [15:0] mem [RAM_WORDS];
    logic [15:0] rdata_q;

    // No reset on the read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cdic_regs.sv
// CDIC slave: address decode, register file with command/read-to-clear side effects,
// and a registered output mux shared between the sector RAM and the registers.
module cdic_regs
    import cdic_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    cdic_regs_if.slave  bus
);
    logic [14:0] wofs;
    logic [15:0] bofs, bmask, ram_rdata;
    logic        acc, wr, rd, ram_sel, first, status_rd;
    logic        unused_addr;
    reg_dec_t    dec;

    logic [NUM_REGS-1:0][15:0] regs_q, regs_d;
    logic [15:0] reg_rd_q, reg_rd_d;
    logic [14:0] addr_q;
    logic        acc_q, rd_q, ram_sel_q;

    assign wofs        = bus.address[14:0];
    assign bofs        = {wofs, 1'b0};
    assign unused_addr = ^bus.address[22:15];
    assign bmask       = {{8{bus.uds}}, {8{bus.lds}}};
    assign acc         = bus.cs && (bus.uds || bus.lds);
    assign wr          = acc && bus.write_strobe;
    assign rd          = acc && !bus.write_strobe;
    assign ram_sel     = wofs < 15'(RAM_WORDS);
    assign dec         = reg_decode(bofs);
    assign first       = !acc_q || (wofs != addr_q);
    assign status_rd   = rd && dec.hit && (dec.idx == R_ABUF || dec.idx == R_XBUF);

    cdic_ram u_ram (
        .clk   (clk),
        .addr  (wofs[12:0]),
        .wdata (bus.din),
        .we    ({2{wr && ram_sel}} & {bus.uds, bus.lds}),
        .rdata (ram_rdata)
    );

    always_comb begin
        regs_d = regs_q;
        if (wr && dec.hit) begin
            if (dec.idx == R_CMD) regs_d[R_XBUF][15] = 1'b1;
            regs_d[dec.idx] = (regs_q[dec.idx] & ~bmask) | (bus.din & bmask);
            if (dec.idx == R_FILE) regs_d[R_FILE][15:8] = 8'h00;
        end
        if (status_rd && first) regs_d[dec.idx][15] = 1'b0;
    end

    // A held status read keeps showing the pre-clear value for the whole access.
    always_comb begin
        reg_rd_d = '0;
        if (dec.hit) reg_rd_d = regs_q[dec.idx];
        if (status_rd && rd_q && (wofs == addr_q)) reg_rd_d = reg_rd_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q    <= regs_rst();
            reg_rd_q  <= '0;
            addr_q    <= '0;
            acc_q     <= 1'b0;
            rd_q      <= 1'b0;
            ram_sel_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            reg_rd_q  <= reg_rd_d;
            addr_q    <= wofs;
            acc_q     <= acc;
            rd_q      <= rd;
            ram_sel_q <= ram_sel;
        end
    end

    assign bus.dout = ram_sel_q ? ram_rdata : reg_rd_q;
endmodule

// File: tb/tb_cdic_regs.sv
// Directed bench for cdic_regs: reset values, RAM byte lanes, register decode,
// command/read-to-clear side effects, held reads and async reset mid-write.
module tb_cdic_regs;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cdic_regs_if bus ();

    cdic_regs dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.cs = 1'b0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        bus.write_strobe = 1'b0;
    endtask

    task automatic bus_write(input logic [23:0] baddr, input logic [15:0] data,
                             input logic u, input logic l);
        @(posedge clk); #1;
        bus.address = baddr[23:1];
        bus.din = data;
        bus.uds = u;
        bus.lds = l;
        bus.write_strobe = 1'b1;
        bus.cs = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic bus_read(input logic [23:0] baddr, output logic [15:0] data);
        @(posedge clk); #1;
        bus.address = baddr[23:1];
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        bus.write_strobe = 1'b0;
        bus.cs = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        data = bus.dout;
        idle();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        bus.address = 23'(24'h303FFC >> 1);
        bus.din = 16'h0;
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        bus.write_strobe = 1'b0;
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dout got %h exp 0000", bus.dout);
        end
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(24'h303FFC, v);
        checks++;
        if (v !== 16'h0F00) begin errors++; $display("FAIL reset_ivec got %h exp 0f00", v); end
        bus_read(24'h303C00, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h exp 0000", v); end
    endtask

    task automatic test_ram_lanes();
        logic [15:0] v;
        bus_write(24'h300100, 16'h1234, 1'b1, 1'b1);
        bus_write(24'h300100, 16'hAB00, 1'b1, 1'b0);
        bus_read(24'h300100, v);
        checks++;
        if (v !== 16'hAB34) begin errors++; $display("FAIL ram_uds got %h exp ab34", v); end
        bus_write(24'h300100, 16'h99CD, 1'b0, 1'b1);
        bus_read(24'h300100, v);
        checks++;
        if (v !== 16'hABCD) begin errors++; $display("FAIL ram_lds got %h exp abcd", v); end
        bus_write(24'h303BFE, 16'hFFFF, 1'b1, 1'b1);
        bus_read(24'h303BFE, v);
        checks++;
        if (v !== 16'hFFFF) begin errors++; $display("FAIL ram_top got %h exp ffff", v); end
        bus_read(24'h300100, v);
        checks++;
        if (v !== 16'hABCD) begin errors++; $display("FAIL ram_keep got %h exp abcd", v); end
    endtask

    task automatic test_file_and_holes();
        logic [15:0] v;
        bus_write(24'h303C06, 16'hFFFF, 1'b1, 1'b1);
        bus_read(24'h303C06, v);
        checks++;
        if (v !== 16'h00FF) begin errors++; $display("FAIL file_mask got %h exp 00ff", v); end
        bus_write(24'h303C10, 16'hFFFF, 1'b1, 1'b1);
        bus_read(24'h303C10, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL hole_3c10 got %h exp 0000", v); end
        bus_read(24'h303C0E, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL hole_3c0e got %h exp 0000", v); end
        bus_write(24'h304000, 16'hBEEF, 1'b1, 1'b1);
        bus_read(24'h304000, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL hole_4000 got %h exp 0000", v); end
        bus_read(24'h300100, v);
        checks++;
        if (v !== 16'hABCD) begin errors++; $display("FAIL ram_alias got %h exp abcd", v); end
        bus_read(24'h303C00, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL hole_cmd got %h exp 0000", v); end
        bus_read(24'h303FFC, v);
        checks++;
        if (v !== 16'h0F00) begin errors++; $display("FAIL hole_ivec got %h exp 0f00", v); end
    endtask

    task automatic test_cmd_clear();
        logic [15:0] v;
        bus_write(24'h303C00, 16'h002A, 1'b1, 1'b1);
        bus_read(24'h303C00, v);
        checks++;
        if (v !== 16'h002A) begin errors++; $display("FAIL cmd_value got %h exp 002a", v); end
        bus_read(24'h303FF6, v);
        checks++;
        if (v !== 16'h8000) begin errors++; $display("FAIL xbuf_set got %h exp 8000", v); end
        bus_read(24'h303FF6, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL xbuf_clr got %h exp 0000", v); end
    endtask

    task automatic test_held_read();
        logic [15:0] v;
        bus_write(24'h303FF4, 16'h8001, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.address = 23'(24'h303FF4 >> 1);
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        bus.write_strobe = 1'b0;
        bus.cs = 1'b1;
        @(posedge clk);
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.dout !== 16'h8001) begin
                errors++;
                $display("FAIL held_abuf cycle %0d got %h exp 8001", c, bus.dout);
            end
        end
        idle();
        bus_read(24'h303FF4, v);
        checks++;
        if (v !== 16'h0001) begin errors++; $display("FAIL abuf_after got %h exp 0001", v); end
    endtask

    task automatic test_lane_reg_and_cs_low();
        logic [15:0] v;
        bus_write(24'h303FFC, 16'h12FF, 1'b1, 1'b0);
        bus_read(24'h303FFC, v);
        checks++;
        if (v !== 16'h1200) begin errors++; $display("FAIL ivec_uds got %h exp 1200", v); end
        @(posedge clk); #1;
        bus.address = 23'(24'h303C06 >> 1);
        @(posedge clk); #1;
        checks++;
        if (bus.dout !== 16'h00FF) begin
            errors++;
            $display("FAIL cs_low_dout got %h exp 00ff", bus.dout);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] v;
        bus_write(24'h303FF8, 16'h1111, 1'b1, 1'b1);
        bus_read(24'h303FF8, v);
        checks++;
        if (v !== 16'h1111) begin errors++; $display("FAIL dmactl_pre got %h exp 1111", v); end
        @(posedge clk); #1;
        bus.address = 23'(24'h303FF8 >> 1);
        bus.din = 16'h5555;
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        bus.write_strobe = 1'b1;
        bus.cs = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 16'h0000) begin
            errors++;
            $display("FAIL async_dout got %h exp 0000", bus.dout);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(24'h303FF8, v);
        checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL dmactl_rst got %h exp 0000", v); end
        bus_read(24'h303FFC, v);
        checks++;
        if (v !== 16'h0F00) begin errors++; $display("FAIL ivec_rst got %h exp 0f00", v); end
    endtask

    initial begin
        bus.address = '0;
        bus.din = '0;
        idle();
        test_reset();
        test_ram_lanes();
        test_file_and_holes();
        test_cmd_clear();
        test_held_read();
        test_lane_reg_and_cs_low();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
